// File: rtl/timer_pkg.sv
// Shared constants, types and helpers for the egg-timer board logic.
package timer_pkg;

    // Debounce window for a 100 MHz system clock: 1 ms of stable input.
    localparam int unsigned DB_COUNT_100MHZ = 100000;

    // Legal synchroniser depth, in flops.
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Debounced state of one channel; the encoding doubles as the level bit.
    typedef enum logic {
        STABLE0 = 1'b0,
        STABLE1 = 1'b1
    } chan_state_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, registered level
// and single-cycle rise/fall pulses.
module debounce_channel
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = DB_COUNT_100MHZ,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W   = (clog2(DB_COUNT) < 1) ? 1 : clog2(DB_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    chan_state_e            state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // State register: synchroniser, counter, debounced state and pulse flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= STABLE0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: shift the sync chain and count consecutive disagreeing samples.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in ^ ACTIVE_LOW};
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample != logic'(state_q)) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sample ? STABLE1 : STABLE0;
                rise_d  = sample;
                fall_d  = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Outputs come straight from flops, so raw_in never reaches them combinationally.
    always_comb begin
        level = (state_q == STABLE1);
        rise  = rise_q;
        fall  = fall_q;
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel debouncer for board push-buttons and switches; each channel
// is an independent debounce_channel instance.
module input_conditioner
    import timer_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = DB_COUNT_100MHZ,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("input_conditioner: CHANNELS must be at least 1");
    end

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be in 2..4");
    end

    if (DB_COUNT < 1) begin : g_bad_db
        $error("input_conditioner: DB_COUNT must be at least 1");
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw_in (raw_in[ch]),
            .level  (level[ch]),
            .rise   (rise[ch]),
            .fall   (fall[ch])
        );
    end

endmodule
